vga_pixel_fetch: RTL
====================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of framebuffer word for pixel 0.
REQ-002 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, prefetch FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port pix_en  input  1  pixel-rate enable (one clk in two for 25 MHz).
REQ-008 SHALL have port frame_start  input  1  one-clk pulse at start of vertical blanking, restarts frame.
REQ-009 SHALL have port pix_req  input  1  VGA consumes one pixel, valid only when pix_en=1.
REQ-010 SHALL have port rd_addr  output  32  byte address to data-memory second read port.
REQ-011 SHALL have port rd_data  input  32  asynchronous read data for rd_addr, same cycle.
REQ-012 SHALL have port pixel  output  24  registered RGB pixel {R,G,B} = word bits [23:0].
REQ-013 SHALL have port underflow  output  1  sticky flag, pop attempted on empty FIFO.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DONE.
REQ-015 IDLE: no fetches; on frame_start -> FETCH with index=0, FIFO flushed.
REQ-016 FETCH: each clk with FIFO not full (count at start of cycle), SHALL push rd_data[23:0] and increment index.
REQ-017 rd_addr SHALL equal BASE_ADDR + 4*index at all times, index width ceil(log2(H_RES*V_RES)).
REQ-018 After push of index H_RES*V_RES-1, SHALL go to DONE, index wraps to 0; no further pushes.
REQ-019 DONE: on frame_start -> FETCH, index=0, FIFO flushed.
REQ-020 frame_start in FETCH SHALL restart identically (flush, index=0), discarding in-flight frame.
REQ-021 Pop occurs when pix_en=1 and pix_req=1: non-empty -> pixel <= FIFO head; empty -> pixel <= 24'h000000, underflow <= 1.
REQ-022 pixel SHALL hold its value when no pop occurs.
REQ-023 Push and pop in same cycle SHALL both occur; full-check uses pre-pop count (no push when full even if popping).
REQ-024 frame_start SHALL take priority over push and pop in the same cycle; pixel <= 24'h000000, count=0.
REQ-025 Pop latency: pixel updates on the clk edge where pop is sampled (one-cycle registered).
REQ-026 underflow SHALL clear only on reset (not on frame_start).
REQ-027 FIFO SHALL preserve order; count range 0..FIFO_DEPTH, never exceeded.

Reset
REQ-028 reset=0 at a rising edge SHALL force state=IDLE, index=0, FIFO count=0, rd_addr=BASE_ADDR, pixel=24'h000000, underflow=0.
REQ-029 Reset mid-frame SHALL abandon the frame; fetching resumes only after next frame_start.
REQ-030 frame_start, pix_req ignored while reset=0.

Configuration
REQ-031 Macro PIXFETCH_UNDERFLOW_CNT_EN: when defined, SHALL add output underflow_cnt (16 bits), incremented per empty pop, saturating at 16'hFFFF, reset to 0, cleared on frame_start.
REQ-032 Without PIXFETCH_UNDERFLOW_CNT_EN, underflow_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, then frame_start, no pix_req, rd_data=index pattern -> exactly 8 pushes, rd_addr stops at BASE_ADDR+32, FIFO full.
REQ-034 Continuous pops every other clk after fill, rd_data=0x00ABCDEF+index -> pixel sequence 0xABCDEF,0xABCDF0,... in order, underflow=0.
REQ-035 H_RES=4,V_RES=2 full drain -> 8 pixels then DONE, rd_addr=BASE_ADDR, further pops give 0x000000 and underflow=1.
REQ-036 frame_start asserted same cycle as pop and push at index 5 -> pixel=0, count=0, rd_addr=BASE_ADDR next cycle.
REQ-037 reset=0 mid-FETCH at index 100 -> all outputs at reset values; no pushes until frame_start.
REQ-038 With PIXFETCH_UNDERFLOW_CNT_EN, 3 pops on empty FIFO -> underflow_cnt=3; frame_start -> 0; underflow stays 1.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams framebuffer words from memory into a small prefetch FIFO
// and hands one RGB pixel per VGA pop request.
// Optional feature: define PIXFETCH_UNDERFLOW_CNT_EN to add a 16-bit saturating
// underflow event counter output (underflow_cnt).
module vga_pixel_fetch #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        frame_start,
    input  logic        pix_req,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic [23:0] pixel,
    output logic        underflow
`ifdef PIXFETCH_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [23:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push, pop, pop_hit, last_px;

    // Upper byte of the framebuffer word carries no colour information.
    logic unused_hi;
    assign unused_hi = ^rd_data[31:24];

    // The fetch address is a pure function of the pixel index.
    assign rd_addr = BASE_ADDR + (32'(idx) << 2);

    // Push/pop qualifiers; fullness and emptiness use the count at cycle start.
    always_comb begin
        push    = (state == FETCH) && (count != CNT_W'(FIFO_DEPTH));
        pop     = pix_en && pix_req;
        pop_hit = pop && (count != '0);
        last_px = (idx == IDX_W'(TOTAL - 1));
    end

    // Next-state logic: frame_start always (re)starts a frame, last push ends it.
    always_comb begin
        state_nxt = state;
        if (frame_start)
            state_nxt = FETCH;
        else if (push && last_px)
            state_nxt = DONE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Pixel index and FIFO bookkeeping; frame_start flushes and overrides push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (frame_start) begin
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                idx    <= last_px ? '0 : idx + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_hit)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_hit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (reset && !frame_start && push)
            mem[wr_ptr] <= rd_data[23:0];
    end

    // Registered pixel output and sticky underflow flag (survives frame_start).
    always_ff @(posedge clk) begin
        if (!reset) begin
            pixel     <= '0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            pixel     <= '0;
        end else if (pop) begin
            if (pop_hit) begin
                pixel <= mem[rd_ptr];
            end else begin
                pixel     <= '0;
                underflow <= 1'b1;
            end
        end
    end

`ifdef PIXFETCH_UNDERFLOW_CNT_EN
    // Saturating count of empty pops, cleared per frame.
    always_ff @(posedge clk) begin
        if (!reset)
            underflow_cnt <= '0;
        else if (frame_start)
            underflow_cnt <= '0;
        else if (pop && !pop_hit && (underflow_cnt != 16'hFFFF))
            underflow_cnt <= underflow_cnt + 1'b1;
    end
`endif

endmodule
